ifstage_fetch_unit: RTL and testbench
=====================================

# ifstage_fetch_unit

Instruction fetch stage that supplies the decode stage. It holds the PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered in a 2-entry FIFO and presented to decode over a valid/ready interface. A redirect input (branch/jump target) flushes buffered and in-flight instructions and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- Clk  input  1  clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Mem_req  output  1  fetch request valid.
- Mem_addr  output  32  fetch byte address; always equals PC.
- Mem_gnt  input  1  memory accepts the request this cycle; meaningful only when Mem_req=1.
- Mem_rvalid  input  1  read data valid; asserted the cycle after the grant at the earliest.
- Mem_rdata  input  32  instruction word.
- Redirect  input  1  load a new PC and flush.
- Redirect_addr  input  32  new PC; bits [1:0] are ignored and forced to 0.
- Instr  output  32  head-of-FIFO instruction; 0 when empty.
- Instr_PC  output  32  address of Instr; 0 when empty.
- Instr_valid  output  1  FIFO non-empty.
- Instr_ready  input  1  decode consumes Instr this cycle.

## Operation
- State: PC (32b), FIFO of 2 entries {instr, pc}, count (0–2), FSM.
- FSM has 3 states:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding; its data is kept.
  - DROP: one request outstanding; its data is discarded.
- At most one outstanding request at any time.
- Mem_req = (state==FETCH) && (count<2) && !Redirect. This is combinational; Mem_addr = PC.
- Handshake completes when Mem_req && Mem_gnt. On completion: PC <= PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), and FETCH -> WAIT. The issued address is remembered as the tag for the returning word.
- In WAIT, Mem_rvalid pushes {Mem_rdata, tag} into the FIFO, and WAIT -> FETCH.
- In DROP, Mem_rvalid discards the data, and DROP -> FETCH.
- Mem_rvalid while in FETCH is ignored (protocol violation; no state change).
- Issue is only allowed when count<2 and nothing is outstanding, so a push never overflows.
- Pop: Instr_valid && Instr_ready removes the head. A push and a pop in the same cycle both take effect; count is unchanged.
- Redirect has priority over all other events in its cycle:
  - PC <= {Redirect_addr[31:2], 2'b00}.
  - FIFO is flushed (count <= 0); any pop in the same cycle is a no-op.
  - No request is issued that cycle.
  - FETCH stays FETCH. WAIT -> DROP, unless Mem_rvalid arrives in the same cycle: then the data is discarded and the state goes to FETCH.
  - DROP stays DROP, or goes to FETCH if Mem_rvalid arrives in the same cycle.
- Reset (asynchronous, any time, including mid-transaction):
  - PC = RESET_PC, count = 0, state = FETCH.
  - Mem_req = 0 while Reset_n = 0.
  - Mem_addr = RESET_PC, Instr = 0, Instr_PC = 0, Instr_valid = 0.
  - A response for a request issued before reset is not tracked; the memory side must be reset together with this block.

## Timing
- The first request is asserted in the first cycle with Reset_n = 1.
- Zero-wait memory (gnt in cycle n, rvalid in n+1): Instr_valid rises in n+2, giving a sustained throughput of one instruction per 2 cycles.
- Redirect in cycle n with nothing outstanding: Mem_req=1 with Mem_addr=Redirect_addr in cycle n+1.
- Redirect in cycle n while in WAIT: the next request follows one cycle after the dropped Mem_rvalid.
- Instr, Instr_PC and Instr_valid are registered FIFO outputs; they never depend combinationally on Instr_ready.
- A redirect clears Instr_valid in cycle n+1.

## Test plan
- Zero-wait fetch from reset, with Instr_ready=1 and memory returning addr+32'h100 as data: Mem_addr sequence 0, 4, 8. Decode sees Instr 0x100 with Instr_PC 0, then 0x104 with PC 4, then 0x108 with PC 8. Instr_valid first rises in cycle 2.
- Backpressure, Instr_ready=0: after two words Mem_req stays 0, and Instr holds 0x100 with Instr_PC 0. Raising Instr_ready for one cycle pops one entry; the next cycle issues addr 8.
- Redirect to 0x40 while in WAIT, with the response arriving 2 cycles later: that response is not visible on Instr. The next Mem_addr is 0x40, and the first Instr_PC after the redirect is 0x40.
- Redirect coincident with Mem_rvalid and with a pop while the FIFO is full: the FIFO is empty the next cycle and the data is discarded. Mem_req=1 with Mem_addr = redirect target.
- Reset_n pulsed low mid-WAIT with RESET_PC=32'h0000_0020: all outputs return to their reset values immediately (asynchronously). After release, Mem_addr=0x20.
- Wrap: redirect to 32'hFFFF_FFFC, then fetch: the next Mem_addr is 0, and Instr_PC values are 0xFFFF_FFFC then 0.

Source files
------------

// File: rtl/ifstage_fetch_unit.sv
// ifstage_fetch_unit
//
// Instruction fetch stage. It holds the PC, issues single-word reads to
// instruction memory over a req/gnt/rvalid handshake, buffers returned words
// in a 2-entry FIFO and presents them to decode over a valid/ready interface.
// A redirect flushes buffered and in-flight instructions and restarts fetch
// at a new word-aligned address.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset_n        : asynchronous active-low reset
//   mem_req        : fetch request valid (combinational)
//   mem_addr       : fetch byte address, always equal to the PC
//   mem_gnt        : memory accepts the request this cycle
//   mem_rvalid     : read data valid for the outstanding request
//   mem_rdata      : returned instruction word
//   redirect       : load a new PC and flush everything in flight
//   redirect_addr  : new PC, bits [1:0] forced to zero
//   instr          : head-of-FIFO instruction, 0 when empty
//   instr_pc       : address of instr, 0 when empty
//   instr_valid    : FIFO non-empty
//   instr_ready    : decode consumes instr this cycle

module ifstage_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    input  logic        redirect,
    input  logic [31:0] redirect_addr,

    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    // FETCH: nothing outstanding; WAIT: outstanding, keep data;
    // DROP: outstanding, discard data (killed by a redirect).
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StDrop  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, rd_ptr_q;
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];

    logic issue;
    logic push;
    logic pop;

    // Only the word-aligned part of the redirect target is used.
    logic unused_redirect_addr_lsbs;
    assign unused_redirect_addr_lsbs = ^redirect_addr[1:0];

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------

    // reset_n is folded in so the request is low for the whole reset
    // window, not just after the first clock edge.
    assign mem_req  = reset_n && (state_q == StFetch) && (count_q < 2'd2) && !redirect;
    assign mem_addr = pc_q;
    assign issue    = mem_req && mem_gnt;

    // Redirect kills both the returning word and any pop in its cycle.
    assign push = (state_q == StWait) && mem_rvalid && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    // Outputs depend only on registered state, never on instr_ready.
    assign instr_valid = (count_q != 2'd0);
    assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                // rvalid here is a protocol violation and is ignored.
                if (issue) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response arriving with the redirect is simply dropped.
                if (mem_rvalid) begin
                    state_d = StFetch;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (mem_rvalid) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_addr[31:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Address of the outstanding request, attached to its returning word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= 32'h0;
        end else if (issue) begin
            tag_q <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (redirect) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= 32'h0;
                fifo_pc_q[i]    <= 32'h0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]    <= tag_q;
        end
    end

endmodule

// File: tb/tb_ifstage_fetch_unit.sv
// Self-checking bench for ifstage_fetch_unit. Two instances share all inputs:
// dut0 with RESET_PC = 0 (main checks) and dut20 with RESET_PC = 0x20 (reset
// checks). Each table row is one clock cycle: inputs driven just after the
// rising edge, outputs compared before the next rising edge.

module tb_ifstage_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_ready;

    logic        mem_req0,  mem_req20;
    logic [31:0] mem_addr0, mem_addr20;
    logic [31:0] instr0,    instr20;
    logic [31:0] ipc0,      ipc20;
    logic        ivalid0,   ivalid20;

    int checks;
    int failures;

    ifstage_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req       (mem_req0),
        .mem_addr      (mem_addr0),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr0),
        .instr_pc      (ipc0),
        .instr_valid   (ivalid0),
        .instr_ready   (instr_ready)
    );

    ifstage_fetch_unit #(.RESET_PC(32'h0000_0020)) dut20 (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_req       (mem_req20),
        .mem_addr      (mem_addr20),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr20),
        .instr_pc      (ipc20),
        .instr_valid   (ivalid20),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] raddr;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic redir, input logic [31:0] raddr, input logic ready,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t t;
        t.gnt = gnt; t.rv = rv; t.rdata = rdata; t.redir = redir; t.raddr = raddr;
        t.ready = ready; t.e_req = e_req; t.e_addr = e_addr; t.e_valid = e_valid;
        t.e_instr = e_instr; t.e_pc = e_pc;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        redirect = 1'b0; redirect_addr = 32'h0; instr_ready = 1'b0;
    endtask

    // Leaves the bench at posedge+1 of the first cycle with reset_n = 1.
    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run(input string seq);
        for (int i = 0; i < vq.size(); i++) begin
            mem_gnt = vq[i].gnt; mem_rvalid = vq[i].rv; mem_rdata = vq[i].rdata;
            redirect = vq[i].redir; redirect_addr = vq[i].raddr;
            instr_ready = vq[i].ready;
            #3;
            chk($sformatf("%s[%0d] mem_req", seq, i), {31'h0, mem_req0}, {31'h0, vq[i].e_req});
            chk($sformatf("%s[%0d] mem_addr", seq, i), mem_addr0, vq[i].e_addr);
            chk($sformatf("%s[%0d] instr_valid", seq, i), {31'h0, ivalid0},
                {31'h0, vq[i].e_valid});
            chk($sformatf("%s[%0d] instr", seq, i), instr0, vq[i].e_instr);
            chk($sformatf("%s[%0d] instr_pc", seq, i), ipc0, vq[i].e_pc);
            @(posedge clk);
            #1;
        end
        vq.delete();
        drive_idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        drive_idle();
        reset_n = 1'b0;
        #2;
        chk("por mem_req", {31'h0, mem_req0}, 32'h0);
        chk("por mem_addr", mem_addr0, 32'h0);
        chk("por instr_valid", {31'h0, ivalid0}, 32'h0);

        // Zero-wait fetch, memory returns addr + 0x100, decode always ready.
        do_reset();
        //gnt rv rdata          rd raddr ry  req addr   vld instr          pc
        v(1, 0, 32'h0,         0, 32'h0, 1,  1, 32'h0,  0, 32'h0,         32'h0);
        v(0, 1, 32'h100,       0, 32'h0, 1,  0, 32'h4,  0, 32'h0,         32'h0);
        v(1, 0, 32'h0,         0, 32'h0, 1,  1, 32'h4,  1, 32'h100,       32'h0);
        v(0, 1, 32'h104,       0, 32'h0, 1,  0, 32'h8,  0, 32'h0,         32'h0);
        v(1, 0, 32'h0,         0, 32'h0, 1,  1, 32'h8,  1, 32'h104,       32'h4);
        v(0, 1, 32'h108,       0, 32'h0, 1,  0, 32'hC,  0, 32'h0,         32'h0);
        v(0, 0, 32'h0,         0, 32'h0, 1,  1, 32'hC,  1, 32'h108,       32'h8);
        v(0, 0, 32'h0,         0, 32'h0, 1,  1, 32'hC,  0, 32'h0,         32'h0);
        run("zerowait");

        // Backpressure: two words fill the FIFO, a one-cycle pop frees a slot.
        do_reset();
        v(1, 0, 32'h0,         0, 32'h0, 0,  1, 32'h0,  0, 32'h0,         32'h0);
        v(0, 1, 32'h100,       0, 32'h0, 0,  0, 32'h4,  0, 32'h0,         32'h0);
        v(1, 0, 32'h0,         0, 32'h0, 0,  1, 32'h4,  1, 32'h100,       32'h0);
        v(0, 1, 32'h104,       0, 32'h0, 0,  0, 32'h8,  1, 32'h100,       32'h0);
        v(1, 0, 32'h0,         0, 32'h0, 0,  0, 32'h8,  1, 32'h100,       32'h0);
        v(1, 0, 32'h0,         0, 32'h0, 0,  0, 32'h8,  1, 32'h100,       32'h0);
        v(0, 0, 32'h0,         0, 32'h0, 1,  0, 32'h8,  1, 32'h100,       32'h0);
        v(1, 0, 32'h0,         0, 32'h0, 0,  1, 32'h8,  1, 32'h104,       32'h4);
        v(0, 1, 32'h108,       0, 32'h0, 0,  0, 32'hC,  1, 32'h104,       32'h4);
        v(0, 0, 32'h0,         0, 32'h0, 0,  0, 32'hC,  1, 32'h104,       32'h4);
        run("backpressure");

        // Redirect to 0x43 (-> 0x40) while WAIT; stale response 2 cycles later.
        do_reset();
        v(1, 0, 32'h0,         0, 32'h0,  1, 1, 32'h0,  0, 32'h0,         32'h0);
        v(0, 0, 32'h0,         1, 32'h43, 1, 0, 32'h4,  0, 32'h0,         32'h0);
        v(0, 0, 32'h0,         0, 32'h0,  1, 0, 32'h40, 0, 32'h0,         32'h0);
        v(0, 1, 32'hDEAD_BEEF, 0, 32'h0,  1, 0, 32'h40, 0, 32'h0,         32'h0);
        v(1, 0, 32'h0,         0, 32'h0,  1, 1, 32'h40, 0, 32'h0,         32'h0);
        v(0, 1, 32'h140,       0, 32'h0,  1, 0, 32'h44, 0, 32'h0,         32'h0);
        v(0, 0, 32'h0,         0, 32'h0,  1, 1, 32'h44, 1, 32'h140,       32'h40);
        v(0, 0, 32'h0,         0, 32'h0,  1, 1, 32'h44, 0, 32'h0,         32'h0);
        run("redir_wait");

        // Redirect + rvalid + pop in WAIT, then redirect + rvalid + pop when full.
        do_reset();
        v(1, 0, 32'h0,         0, 32'h0,   0, 1, 32'h0,   0, 32'h0,       32'h0);
        v(0, 1, 32'h100,       0, 32'h0,   0, 0, 32'h4,   0, 32'h0,       32'h0);
        v(1, 0, 32'h0,         0, 32'h0,   0, 1, 32'h4,   1, 32'h100,     32'h0);
        v(0, 1, 32'h104,       1, 32'h80,  1, 0, 32'h8,   1, 32'h100,     32'h0);
        v(1, 0, 32'h0,         0, 32'h0,   0, 1, 32'h80,  0, 32'h0,       32'h0);
        v(0, 1, 32'h180,       0, 32'h0,   0, 0, 32'h84,  0, 32'h0,       32'h0);
        v(1, 0, 32'h0,         0, 32'h0,   0, 1, 32'h84,  1, 32'h180,     32'h80);
        v(0, 1, 32'h184,       0, 32'h0,   0, 0, 32'h88,  1, 32'h180,     32'h80);
        v(0, 1, 32'h999,       1, 32'h200, 1, 0, 32'h88,  1, 32'h180,     32'h80);
        v(0, 0, 32'h0,         0, 32'h0,   0, 1, 32'h200, 0, 32'h0,       32'h0);
        run("redir_full");

        // PC wrap: redirect to 0xFFFF_FFFE (-> 0xFFFF_FFFC), next address is 0.
        do_reset();
        v(0, 0, 32'h0,         1, 32'hFFFF_FFFE, 1, 0, 32'h0,         0, 32'h0,    32'h0);
        v(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,    32'h0);
        v(0, 1, 32'h1234,      0, 32'h0,         1, 0, 32'h0,         0, 32'h0,    32'h0);
        v(1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         1, 32'h1234,
          32'hFFFF_FFFC);
        v(0, 1, 32'h100,       0, 32'h0,         1, 0, 32'h4,         0, 32'h0,    32'h0);
        v(0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h4,         1, 32'h100,  32'h0);
        run("wrap");

        // Asynchronous reset mid-WAIT with one word buffered.
        do_reset();
        mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h555;
        @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1 mem_gnt = 1'b0;
        #1;
        chk("prereset dut20 mem_addr", mem_addr20, 32'h28);
        chk("prereset dut20 instr_valid", {31'h0, ivalid20}, 32'h1);
        chk("prereset dut20 instr_pc", ipc20, 32'h20);
        chk("prereset dut0 instr", instr0, 32'h555);
        mem_gnt = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("async dut20 mem_req", {31'h0, mem_req20}, 32'h0);
        chk("async dut20 mem_addr", mem_addr20, 32'h20);
        chk("async dut20 instr", instr20, 32'h0);
        chk("async dut20 instr_pc", ipc20, 32'h0);
        chk("async dut20 instr_valid", {31'h0, ivalid20}, 32'h0);
        chk("async dut0 mem_addr", mem_addr0, 32'h0);
        chk("async dut0 mem_req", {31'h0, mem_req0}, 32'h0);
        @(posedge clk);
        #1;
        chk("inreset dut20 mem_req", {31'h0, mem_req20}, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1; mem_gnt = 1'b0;
        #1;
        chk("release dut20 mem_req", {31'h0, mem_req20}, 32'h1);
        chk("release dut20 mem_addr", mem_addr20, 32'h20);
        chk("release dut0 mem_addr", mem_addr0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
